// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: tracks note/enable/age per voice, allocates on note-on,
// releases on note-off, and optionally steals the oldest voice when all are busy.
module voice_alloc #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned NOTE_W = 8,
  parameter bit          STEAL  = 1'b1,
  parameter int unsigned CNT_W  = $clog2(VOICES + 1)
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic [NOTE_W-1:0]        note_i,
  input  logic                     noteOnStrb_i,
  input  logic                     noteOffStrb_i,
  input  logic                     allOffStrb_i,
  output logic [VOICES*NOTE_W-1:0] voiceNote_o,
  output logic [VOICES-1:0]        voiceEn_o,
  output logic [VOICES-1:0]        voiceRetrig_o,
  output logic                     droppedStrb_o,
  output logic [CNT_W-1:0]         activeCount_o
);

  localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic [NOTE_W-1:0] note_q [VOICES];
  logic [NOTE_W-1:0] note_n [VOICES];
  logic [IDX_W-1:0]  age_q  [VOICES];
  logic [IDX_W-1:0]  age_n  [VOICES];
  logic [VOICES-1:0] en_q, en_n;
  logic [VOICES-1:0] retrig_q, retrig_n;
  logic              dropped_q, dropped_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              pend_vld_q, pend_vld_n;
  logic [NOTE_W-1:0] pend_note_q, pend_note_n;

  logic              do_on, do_off;
  logic [NOTE_W-1:0] on_note;
  logic [IDX_W-1:0]  rel_age;
  logic              hit, free, tgt_ok, tgt_act;
  logic [IDX_W-1:0]  hit_idx, free_idx, old_idx, tgt, tgt_age;

  // Next-state: all-off overrides; a pending note-on takes priority over a new note-on.
  always_comb begin
    en_n        = en_q;
    note_n      = note_q;
    age_n       = age_q;
    pend_vld_n  = pend_vld_q;
    pend_note_n = pend_note_q;
    retrig_n    = '0;
    dropped_n   = 1'b0;
    cnt_n       = '0;
    do_on       = 1'b0;
    do_off      = 1'b0;
    on_note     = note_i;
    rel_age     = '0;
    hit         = 1'b0;
    free        = 1'b0;
    tgt_ok      = 1'b0;
    tgt_act     = 1'b0;
    hit_idx     = '0;
    free_idx    = '0;
    old_idx     = '0;
    tgt         = '0;
    tgt_age     = '0;

    if (allOffStrb_i) begin
      en_n       = '0;
      pend_vld_n = 1'b0;
      for (int unsigned v = 0; v < VOICES; v++) begin
        age_n[v] = '0;
      end
    end else begin
      if (pend_vld_q) begin
        do_on      = 1'b1;
        on_note    = pend_note_q;
        do_off     = noteOffStrb_i;
        dropped_n  = noteOnStrb_i;
        pend_vld_n = 1'b0;
      end else if (noteOnStrb_i && noteOffStrb_i) begin
        do_off      = 1'b1;
        pend_vld_n  = 1'b1;
        pend_note_n = note_i;
      end else begin
        do_on  = noteOnStrb_i;
        do_off = noteOffStrb_i;
      end

      // Release: voices older than the released one move one rank younger.
      if (do_off) begin
        for (int unsigned v = 0; v < VOICES; v++) begin
          if (en_n[v] && (note_n[v] == note_i)) begin
            rel_age  = age_n[v];
            en_n[v]  = 1'b0;
            age_n[v] = '0;
            for (int unsigned w = 0; w < VOICES; w++) begin
              if (en_n[w] && (age_n[w] > rel_age)) begin
                age_n[w] = age_n[w] - IDX_W'(1);
              end
            end
          end
        end
      end

      if (do_on) begin
        for (int unsigned v = 0; v < VOICES; v++) begin
          if (en_n[v] && (note_n[v] == on_note)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(v);
          end
          if (!en_n[v] && !free) begin
            free     = 1'b1;
            free_idx = IDX_W'(v);
          end
          if (en_n[v] && (age_n[v] == IDX_W'(VOICES - 1))) begin
            old_idx = IDX_W'(v);
          end
        end

        if (hit) begin
          tgt_ok = 1'b1;
          tgt    = hit_idx;
        end else if (free) begin
          tgt_ok = 1'b1;
          tgt    = free_idx;
        end else if (STEAL) begin
          tgt_ok = 1'b1;
          tgt    = old_idx;
        end else begin
          dropped_n = 1'b1;
        end

        // Target becomes newest; only voices younger than it (or all, if it was idle) age.
        if (tgt_ok) begin
          tgt_act = en_n[tgt];
          tgt_age = age_n[tgt];
          for (int unsigned w = 0; w < VOICES; w++) begin
            if (en_n[w] && (IDX_W'(w) != tgt) && (!tgt_act || (age_n[w] < tgt_age))) begin
              age_n[w] = age_n[w] + IDX_W'(1);
            end
          end
          en_n[tgt]     = 1'b1;
          note_n[tgt]   = on_note;
          age_n[tgt]    = '0;
          retrig_n[tgt] = 1'b1;
        end
      end
    end

    for (int unsigned v = 0; v < VOICES; v++) begin
      cnt_n = cnt_n + CNT_W'(en_n[v]);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      en_q        <= '0;
      retrig_q    <= '0;
      dropped_q   <= 1'b0;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_note_q <= '0;
      for (int unsigned v = 0; v < VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      en_q        <= en_n;
      retrig_q    <= retrig_n;
      dropped_q   <= dropped_n;
      cnt_q       <= cnt_n;
      pend_vld_q  <= pend_vld_n;
      pend_note_q <= pend_note_n;
      note_q      <= note_n;
      age_q       <= age_n;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_note_out
    assign voiceNote_o[g*NOTE_W +: NOTE_W] = note_q[g];
  end

  assign voiceEn_o     = en_q;
  assign voiceRetrig_o = retrig_q;
  assign droppedStrb_o = dropped_q;
  assign activeCount_o = cnt_q;

endmodule
